// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue controller that sits between an instruction source and a registered
// ALU. It accepts one instruction at a time, reads both operands from an
// internal register file, presents them to the ALU, captures the ALU result
// two cycles after the instruction was accepted and writes it back to the
// destination register.
//
// Instruction word layout (instr_data):
//   [31:28] funct  (0 = NOP, 1..15 = ALU function)
//   [27:23] rd     destination register
//   [22:18] rs     source register for operand a
//   [17:13] rt     source register for operand b
//   [12:8]  shamt  shift amount passed straight through
//   [7:0]   unused
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   instr_valid/ready     instruction handshake (see below)
//   instr_data            instruction word
//   ld_en/addr/data       host preload of one register (IDLE only)
//   alu_a/b/shamt/funct   registered operands and function to the ALU
//   alu_res               registered ALU result, valid during WB
//   done                  one-cycle pulse when an instruction retires
//   busy                  high while an instruction is in ISSUE or WB
//   dbg_addr/dbg_data     combinational register-file read port
//   zflag                 (only with ISSUE_CTRL_ZFLAG_EN) alu_res==0 at
//                         the most recent write-back
//
// Build option: define ISSUE_CTRL_ZFLAG_EN to add the zflag output.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready depends only on the controller
// state (high in IDLE, low in ISSUE and WB), never on instr_valid, so the
// source may hold instr_valid and instr_data stable until the transfer.
//
// Register file: R0 and any index >= NREGS read as zero and discard writes.
// Indices are 5 bits wide, so NREGS is meaningful only up to 32.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr_data,

  input  logic             ld_en,
  input  logic [4:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_res,

  output logic             done,
  output logic             busy,
`ifdef ISSUE_CTRL_ZFLAG_EN
  output logic             zflag,
`endif

  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t           state;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] regs [NREGS];

  // Instruction fields
  logic [3:0] in_funct;
  logic [4:0] in_rd;
  logic [4:0] in_rs;
  logic [4:0] in_rt;
  logic [4:0] in_shamt;
  logic       unused_instr_bits;

  assign in_funct          = instr_data[31:28];
  assign in_rd             = instr_data[27:23];
  assign in_rs             = instr_data[22:18];
  assign in_rt             = instr_data[17:13];
  assign in_shamt          = instr_data[12:8];
  assign unused_instr_bits = ^instr_data[7:0];

  // Register-file read: R0 and out-of-range indices return zero because the
  // loop never visits them.
  function automatic logic [WIDTH-1:0] rf_read(input logic [4:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (idx == 5'(i)) v = regs[i];
    end
    return v;
  endfunction

  logic             accept;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  // Single register-file write port shared by write-back and host preload.
  logic             we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;

  always_comb begin
    instr_ready = (state == S_IDLE);
    busy        = (state == S_ISSUE) || (state == S_WB);
    accept      = instr_valid && instr_ready;
    rs_val      = rf_read(in_rs);
    rt_val      = rf_read(in_rt);
    dbg_data    = rf_read(dbg_addr);

    // Write-back owns the port in WB. A preload is honoured only in an IDLE
    // cycle with no accept, so an instruction arriving on the same edge wins.
    we = 1'b0;
    wa = ld_addr;
    wd = ld_data;
    if (state == S_WB) begin
      we = 1'b1;
      wa = rd_q;
      wd = alu_res;
    end else if ((state == S_IDLE) && !accept && ld_en) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_q      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shamt <= '0;
      alu_funct <= '0;
      done      <= 1'b0;
`ifdef ISSUE_CTRL_ZFLAG_EN
      zflag     <= 1'b0;
`endif
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      // Index 0 is skipped, which discards writes to R0.
      for (int i = 1; i < NREGS; i++) begin
        if (we && (wa == 5'(i))) regs[i] <= wd;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            // Operands are sampled at accept. The previous instruction has
            // already written back, so no forwarding path is needed.
            alu_a     <= rs_val;
            alu_b     <= rt_val;
            alu_shamt <= in_shamt;
            alu_funct <= in_funct;
            rd_q      <= in_rd;
            if (in_funct != 4'd0) begin
              state <= S_ISSUE;
            end else begin
              // NOP retires immediately; alu_funct stays 0 so the ALU holds.
              done <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          // Operands are stable for this whole cycle; the ALU registers its
          // result on the closing edge.
          state <= S_WB;
        end

        S_WB: begin
          // alu_res is valid now; the register write happens through the
          // shared write port above.
          alu_funct <= 4'd0;
          done      <= 1'b1;
`ifdef ISSUE_CTRL_ZFLAG_EN
          zflag     <= (alu_res == '0);
`endif
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
